slip_receiver: RTL and testbench



---
 rtl/slip_pkg.sv | 26 ++
 rtl/uart_rx.sv | 102 ++++++++++
 rtl/slip_receiver.sv | 129 ++++++++++++
 tb/tb_slip_receiver.sv | 233 +++++++++++++++++++++++
 4 files changed

// File: rtl/slip_pkg.sv
// Shared SLIP framing constants and state encodings for the SLIP receive path.
// The byte constants are shared with slip_sender so both ends agree on framing.
package slip_pkg;

   localparam logic [7:0] SLIP_END     = 8'hC0;
   localparam logic [7:0] SLIP_ESC     = 8'hDB;
   localparam logic [7:0] SLIP_ESC_END = 8'hDC;
   localparam logic [7:0] SLIP_ESC_ESC = 8'hDD;

   // Decoder states: hunting for an END, inside a frame, after an ESC byte.
   typedef enum logic [1:0] {
      S_HUNT = 2'd0,
      S_DATA = 2'd1,
      S_ESC  = 2'd2
   } dec_state_t;

   // UART receiver states.
   typedef enum logic [2:0] {
      RX_IDLE      = 3'd0,
      RX_START     = 3'd1,
      RX_DATA      = 3'd2,
      RX_STOP      = 3'd3,
      RX_WAIT_HIGH = 3'd4
   } rx_state_t;

endpackage

// File: rtl/uart_rx.sv
// 8N1 UART receiver with mid-bit sampling.
// Ports:
//   clk, reset  - system clock, synchronous active-high reset
//   i_rx_line   - asynchronous serial line, idle high
//   o_byte      - received byte, valid with o_valid
//   o_valid     - one-cycle strobe for a byte with a good stop bit
//   o_ferr      - one-cycle strobe for a byte whose stop bit was 0
module uart_rx
   import slip_pkg::*;
#(
   parameter int unsigned CLK_FREQ  = 20000000,
   parameter int unsigned BAUD_RATE = 115200
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       i_rx_line,
   output logic [7:0] o_byte,
   output logic       o_valid,
   output logic       o_ferr
);

   localparam int unsigned CLKS_PER_BIT = CLK_FREQ / BAUD_RATE;
   localparam int unsigned HALF_BIT     = CLKS_PER_BIT / 2;
   localparam int unsigned CNT_W        = $clog2(CLKS_PER_BIT);

   rx_state_t        state;
   logic             rx_meta;
   logic             rx_sync;
   logic             rx_prev;
   logic [CNT_W-1:0] cnt;
   logic [2:0]       bit_idx;
   logic [7:0]       shreg;

   // Synchroniser, bit timing and byte assembly.
   always_ff @(posedge clk) begin
      if (reset) begin
         rx_meta <= 1'b1;
         rx_sync <= 1'b1;
         rx_prev <= 1'b1;
         state   <= RX_IDLE;
         cnt     <= '0;
         bit_idx <= '0;
         shreg   <= '0;
         o_byte  <= '0;
         o_valid <= 1'b0;
         o_ferr  <= 1'b0;
      end else begin
         rx_meta <= i_rx_line;
         rx_sync <= rx_meta;
         rx_prev <= rx_sync;
         o_valid <= 1'b0;
         o_ferr  <= 1'b0;
         case (state)
            RX_IDLE: begin
               cnt     <= '0;
               bit_idx <= '0;
               if (rx_prev && !rx_sync) state <= RX_START;
            end
            RX_START: begin
               // A start bit that is high again at mid-bit was a glitch.
               if (cnt == CNT_W'(HALF_BIT - 1)) begin
                  cnt   <= '0;
                  state <= rx_sync ? RX_IDLE : RX_DATA;
               end else begin
                  cnt <= cnt + CNT_W'(1);
               end
            end
            RX_DATA: begin
               if (cnt == CNT_W'(CLKS_PER_BIT - 1)) begin
                  cnt     <= '0;
                  shreg   <= {rx_sync, shreg[7:1]};
                  bit_idx <= bit_idx + 3'd1;
                  if (bit_idx == 3'd7) state <= RX_STOP;
               end else begin
                  cnt <= cnt + CNT_W'(1);
               end
            end
            RX_STOP: begin
               if (cnt == CNT_W'(CLKS_PER_BIT - 1)) begin
                  cnt <= '0;
                  if (rx_sync) begin
                     o_byte  <= shreg;
                     o_valid <= 1'b1;
                     state   <= RX_IDLE;
                  end else begin
                     o_ferr <= 1'b1;
                     state  <= RX_WAIT_HIGH;
                  end
               end else begin
                  cnt <= cnt + CNT_W'(1);
               end
            end
            RX_WAIT_HIGH: begin
               // Don't rearm on a line still held low after a framing error.
               if (rx_sync) state <= RX_IDLE;
            end
            default: state <= RX_IDLE;
         endcase
      end
   end

endmodule

// File: rtl/slip_receiver.sv
// SLIP (RFC 1055) receiver: UART deserialiser plus frame decoder.
// Ports:
//   clk, reset     - system clock, synchronous active-high reset
//   i_uart_rx_line - asynchronous UART line, idle high
//   o_data         - decoded payload byte, valid with o_data_valid
//   o_data_valid   - one-cycle strobe per payload byte
//   o_frame_start  - with o_data_valid on the first byte of a frame
//   o_frame_end    - one-cycle pulse when END closes a non-empty frame
//   o_frame_len    - payload length, updated with o_frame_end and held
//   o_frame_error  - one-cycle pulse on protocol, overflow or framing error
module slip_receiver
   import slip_pkg::*;
#(
   parameter int unsigned CLK_FREQ      = 20000000,
   parameter int unsigned BAUD_RATE     = 115200,
   parameter int unsigned MAX_FRAME_LEN = 255
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       i_uart_rx_line,
   output logic [7:0] o_data,
   output logic       o_data_valid,
   output logic       o_frame_start,
   output logic       o_frame_end,
   output logic [7:0] o_frame_len,
   output logic       o_frame_error
);

   logic [7:0] rx_byte;
   logic       rx_valid;
   logic       rx_ferr;
   dec_state_t state;
   logic [7:0] len;
   logic       emit_req;
   logic [7:0] emit_byte;

   uart_rx #(
      .CLK_FREQ  (CLK_FREQ),
      .BAUD_RATE (BAUD_RATE)
   ) u_uart_rx (
      .clk       (clk),
      .reset     (reset),
      .i_rx_line (i_uart_rx_line),
      .o_byte    (rx_byte),
      .o_valid   (rx_valid),
      .o_ferr    (rx_ferr)
   );

   // Bytes that become payload: plain data bytes and completed escape pairs.
   always_comb begin
      emit_req  = 1'b0;
      emit_byte = rx_byte;
      if (rx_valid) begin
         if (state == S_DATA)
            emit_req = (rx_byte != SLIP_END) && (rx_byte != SLIP_ESC);
         else if (state == S_ESC)
            emit_req = (rx_byte == SLIP_ESC_END) || (rx_byte == SLIP_ESC_ESC);
      end
      if (state == S_ESC)
         emit_byte = (rx_byte == SLIP_ESC_END) ? SLIP_END : SLIP_ESC;
   end

   // Decoder FSM, length counter and registered outputs.
   always_ff @(posedge clk) begin
      if (reset) begin
         state         <= S_HUNT;
         len           <= '0;
         o_data        <= '0;
         o_data_valid  <= 1'b0;
         o_frame_start <= 1'b0;
         o_frame_end   <= 1'b0;
         o_frame_len   <= '0;
         o_frame_error <= 1'b0;
      end else begin
         o_data_valid  <= 1'b0;
         o_frame_start <= 1'b0;
         o_frame_end   <= 1'b0;
         o_frame_error <= 1'b0;
         if (rx_ferr) begin
            // A broken byte only matters once we are inside a frame.
            if (state != S_HUNT) begin
               o_frame_error <= 1'b1;
               len           <= '0;
               state         <= S_HUNT;
            end
         end else if (emit_req) begin
            if (len == 8'(MAX_FRAME_LEN)) begin
               o_frame_error <= 1'b1;
               len           <= '0;
               state         <= S_HUNT;
            end else begin
               o_data        <= emit_byte;
               o_data_valid  <= 1'b1;
               o_frame_start <= (len == 8'd0);
               len           <= len + 8'd1;
               state         <= S_DATA;
            end
         end else if (rx_valid) begin
            case (state)
               S_HUNT: begin
                  if (rx_byte == SLIP_END) begin
                     len   <= '0;
                     state <= S_DATA;
                  end
               end
               S_DATA: begin
                  if (rx_byte == SLIP_END) begin
                     if (len != 8'd0) begin
                        o_frame_end <= 1'b1;
                        o_frame_len <= len;
                        len         <= '0;
                     end
                  end else begin
                     state <= S_ESC;
                  end
               end
               S_ESC: begin
                  // Bad escape: END still marks a frame boundary, others resync.
                  o_frame_error <= 1'b1;
                  len           <= '0;
                  state         <= (rx_byte == SLIP_END) ? S_DATA : S_HUNT;
               end
               default: state <= S_HUNT;
            endcase
         end
      end
   end

endmodule

// File: tb/tb_slip_receiver.sv
// Testbench for slip_receiver: two instances (default and 4-byte frame limit)
// share one serial line; decoded events are compared with a frame-level model.
module tb_slip_receiver;
   import slip_pkg::*;

   localparam int unsigned CLK_FREQ  = 20000000;
   localparam int unsigned BAUD_RATE = 2000000;
   localparam int unsigned CPB       = CLK_FREQ / BAUD_RATE;

   logic clk = 1'b0;
   logic reset = 1'b1;
   logic line = 1'b1;

   logic [7:0] a_data, a_len, b_data, b_len;
   logic       a_valid, a_start, a_end, a_err;
   logic       b_valid, b_start, b_end, b_err;

   always #5 clk = ~clk;

   slip_receiver #(
      .CLK_FREQ(CLK_FREQ), .BAUD_RATE(BAUD_RATE), .MAX_FRAME_LEN(255)
   ) dut (
      .clk(clk), .reset(reset), .i_uart_rx_line(line),
      .o_data(a_data), .o_data_valid(a_valid), .o_frame_start(a_start),
      .o_frame_end(a_end), .o_frame_len(a_len), .o_frame_error(a_err)
   );

   slip_receiver #(
      .CLK_FREQ(CLK_FREQ), .BAUD_RATE(BAUD_RATE), .MAX_FRAME_LEN(4)
   ) dut_small (
      .clk(clk), .reset(reset), .i_uart_rx_line(line),
      .o_data(b_data), .o_data_valid(b_valid), .o_frame_start(b_start),
      .o_frame_end(b_end), .o_frame_len(b_len), .o_frame_error(b_err)
   );

   int n_vec = 0;
   int n_err = 0;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
      end
   endtask

   // Event word: {kind[1:0], flag, value}; kind 1=data, 2=frame end, 3=error.
   function automatic logic [10:0] ev(input logic [1:0] k, input logic f, input logic [7:0] v);
      return {k, f, v};
   endfunction

   logic [10:0] got_q0[$], got_q1[$], exp_q0[$], exp_q1[$];

   always @(negedge clk) begin
      if (!reset) begin
         if (a_valid) got_q0.push_back(ev(2'd1, a_start, a_data));
         if (a_start && !a_valid) got_q0.push_back(ev(2'd0, 1'b1, 8'h00));
         if (a_end) got_q0.push_back(ev(2'd2, 1'b0, a_len));
         if (a_err) got_q0.push_back(ev(2'd3, 1'b0, 8'h00));
         if (b_valid) got_q1.push_back(ev(2'd1, b_start, b_data));
         if (b_start && !b_valid) got_q1.push_back(ev(2'd0, 1'b1, 8'h00));
         if (b_end) got_q1.push_back(ev(2'd2, 1'b0, b_len));
         if (b_err) got_q1.push_back(ev(2'd3, 1'b0, 8'h00));
      end
   end

   // Reference model: per instance, payload count, hunting/escape flags.
   int plen[2];
   bit hunt[2];
   bit esc[2];
   int last_len[2];
   int mx[2];

   task automatic model_reset();
      for (int m = 0; m < 2; m++) begin
         plen[m] = 0; hunt[m] = 1'b1; esc[m] = 1'b0; last_len[m] = 0;
      end
      mx[0] = 255;
      mx[1] = 4;
   endtask

   task automatic push_exp(input int m, input logic [10:0] e);
      if (m == 0) exp_q0.push_back(e);
      else exp_q1.push_back(e);
   endtask

   task automatic model_err(input int m, input bit to_hunt);
      push_exp(m, ev(2'd3, 1'b0, 8'h00));
      plen[m] = 0;
      esc[m]  = 1'b0;
      if (to_hunt) hunt[m] = 1'b1;
   endtask

   task automatic model_emit(input int m, input logic [7:0] v);
      if (plen[m] == mx[m]) begin
         model_err(m, 1'b1);
      end else begin
         push_exp(m, ev(2'd1, plen[m] == 0, v));
         plen[m]++;
      end
   endtask

   task automatic model_byte(input int m, input logic [7:0] b, input bit ferr);
      if (hunt[m]) begin
         if (!ferr && b == SLIP_END) begin
            hunt[m] = 1'b0; plen[m] = 0; esc[m] = 1'b0;
         end
      end else if (ferr) begin
         model_err(m, 1'b1);
      end else if (esc[m]) begin
         esc[m] = 1'b0;
         if (b == SLIP_ESC_END) model_emit(m, SLIP_END);
         else if (b == SLIP_ESC_ESC) model_emit(m, SLIP_ESC);
         else model_err(m, b != SLIP_END);
      end else if (b == SLIP_END) begin
         if (plen[m] > 0) begin
            push_exp(m, ev(2'd2, 1'b0, 8'(plen[m])));
            last_len[m] = plen[m];
            plen[m] = 0;
         end
      end else if (b == SLIP_ESC) begin
         esc[m] = 1'b1;
      end else begin
         model_emit(m, b);
      end
   endtask

   task automatic send_byte(input logic [7:0] b, input bit ferr);
      @(negedge clk) line = 1'b0;
      repeat (CPB) @(negedge clk);
      for (int i = 0; i < 8; i++) begin
         line = b[i];
         repeat (CPB) @(negedge clk);
      end
      line = ~ferr;
      repeat (CPB) @(negedge clk);
      line = 1'b1;
      repeat (2 * CPB) @(negedge clk);
      for (int m = 0; m < 2; m++) model_byte(m, b, ferr);
   endtask

   task automatic drain(input string tag);
      int n;
      repeat (4 * CPB) @(negedge clk);
      check($sformatf("%s.count0", tag), 32'(got_q0.size()), 32'(exp_q0.size()));
      n = (got_q0.size() < exp_q0.size()) ? got_q0.size() : exp_q0.size();
      for (int i = 0; i < n; i++)
         check($sformatf("%s.ev0[%0d]", tag, i), 32'(got_q0[i]), 32'(exp_q0[i]));
      check($sformatf("%s.count1", tag), 32'(got_q1.size()), 32'(exp_q1.size()));
      n = (got_q1.size() < exp_q1.size()) ? got_q1.size() : exp_q1.size();
      for (int i = 0; i < n; i++)
         check($sformatf("%s.ev1[%0d]", tag, i), 32'(got_q1[i]), 32'(exp_q1[i]));
      check($sformatf("%s.len0", tag), 32'(a_len), 32'(last_len[0]));
      check($sformatf("%s.len1", tag), 32'(b_len), 32'(last_len[1]));
      got_q0.delete(); got_q1.delete(); exp_q0.delete(); exp_q1.delete();
   endtask

   // Bit 8 of each entry forces a 0 stop bit.
   logic [8:0] seq[$];

   task automatic run_seq(input string tag);
      foreach (seq[i]) send_byte(seq[i][7:0], seq[i][8]);
      drain(tag);
   endtask

   task automatic check_reset_outputs(input string tag);
      check({tag, ".a"}, 32'({a_data, a_valid, a_start, a_end, a_len, a_err}), 32'd0);
      check({tag, ".b"}, 32'({b_data, b_valid, b_start, b_end, b_len, b_err}), 32'd0);
   endtask

   initial begin
      int p;
      model_reset();
      repeat (5) @(negedge clk);
      check_reset_outputs("reset_hold");
      reset = 1'b0;
      repeat (5) @(negedge clk);
      check_reset_outputs("reset");

      seq = '{9'h005, 9'h006, 9'h0C0, 9'h0C0, 9'h007, 9'h0C0};
      run_seq("hunt_first");
      seq = '{9'h0C0, 9'h001, 9'h002, 9'h003, 9'h0C0};
      run_seq("basic");
      seq = '{9'h0C0, 9'h041, 9'h0DB, 9'h0DC, 9'h0DB, 9'h0DD, 9'h042, 9'h0C0};
      run_seq("escape");
      seq = '{9'h0C0, 9'h011, 9'h0DB, 9'h055, 9'h022, 9'h0C0, 9'h0C0, 9'h033, 9'h0C0};
      run_seq("bad_escape");
      seq = '{9'h0C0, 9'h0AA, 9'h1BB, 9'h0C0, 9'h0C0, 9'h033, 9'h0C0};
      run_seq("stop_err");

      @(negedge clk) line = 1'b0;
      repeat (2) @(negedge clk);
      line = 1'b1;
      drain("glitch");

      seq = '{9'h0C0, 9'h001, 9'h002, 9'h003, 9'h004, 9'h005, 9'h0C0};
      run_seq("overflow");
      seq = '{9'h0C0, 9'h001, 9'h002, 9'h003, 9'h004, 9'h0C0};
      run_seq("full_frame");

      seq = '{9'h0C0, 9'h001, 9'h002};
      run_seq("pre_reset");
      @(negedge clk) line = 1'b0;
      repeat (4 * CPB) @(negedge clk);
      line  = 1'b1;
      reset = 1'b1;
      repeat (3) @(negedge clk);
      check_reset_outputs("mid_reset");
      reset = 1'b0;
      model_reset();
      repeat (2 * CPB) @(negedge clk);
      seq = '{9'h0C0, 9'h007, 9'h008, 9'h0C0};
      run_seq("post_reset");

      for (int r = 0; r < 8; r++) begin
         seq.delete();
         for (int k = 0; k < 20; k++) begin
            p = int'($urandom_range(0, 99));
            if (p < 20) seq.push_back(9'h0C0);
            else if (p < 32) seq.push_back(9'h0DB);
            else if (p < 38) seq.push_back(9'h0DC);
            else if (p < 44) seq.push_back(9'h0DD);
            else if (p < 48) seq.push_back({1'b1, 8'($urandom)});
            else seq.push_back({1'b0, 8'($urandom)});
         end
         run_seq($sformatf("rand%0d", r));
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
